// File: rtl/pqc_pkg.sv
// Shared ring-LWE definitions: default ring parameters, engine FSM states and
// the decode thresholds that split Z_p into "0" and "1" regions.
package pqc_pkg;

  localparam int P_MOD  = 32'sd17;
  localparam int LOG_P  = 32'sd5;
  localparam int N_RING = 32'sd8;
  localparam int LOG_N  = 32'sd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int q_low(input int pm);
    return pm / 32'sd4;
  endfunction

  function automatic int q_high(input int pm);
    return (32'sd3 * pm) / 32'sd4;
  endfunction

  localparam int Q1 = q_low(P_MOD);
  localparam int Q3 = q_high(P_MOD);

endpackage

// File: rtl/mod_mul_p.sv
// Combinational modular multiplier: r = (a*b) mod p on logP-bit residues.
module mod_mul_p
  import pqc_pkg::*;
#(
  parameter int p    = P_MOD,
  parameter int logP = LOG_P
) (
  input  logic [logP-1:0] a,
  input  logic [logP-1:0] b,
  output logic [logP-1:0] r
);

  localparam logic [2*logP-1:0] P_WIDE = (2*logP)'(p);

  logic [2*logP-1:0] prod_s;
  logic [2*logP-1:0] rem_s;

  // full-width product followed by constant-modulus reduction
  always_comb begin
    prod_s = {{logP{1'b0}}, a} * {{logP{1'b0}}, b};
    rem_s  = prod_s % P_WIDE;
    r      = rem_s[logP-1:0];
  end

endmodule

// File: rtl/dec_rlwe.sv
// Serial ring-LWE decryption: loads s, c0, c1 one coefficient per cycle,
// forms v = c0 + c1*s in Z_p[x]/(x^N+1) term by term and slices v to bits.
module dec_rlwe
  import pqc_pkg::*;
#(
  parameter int p    = P_MOD,
  parameter int logP = LOG_P,
  parameter int N    = N_RING,
  parameter int logN = LOG_N
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            key_ready,
  input  logic [logP-1:0] sec_key,
  input  logic            cipher_ready,
  input  logic [logP-1:0] cipher_c0,
  input  logic [logP-1:0] cipher_c1,
  output logic [N-1:0]    message,
  output logic            msg_valid,
  output logic            busy
);

  localparam logic [logN:0]   CNT_FULL = (logN+1)'(N);
  localparam logic [logN:0]   CNT_LAST = (logN+1)'(N - 32'sd1);
  localparam logic [logN:0]   CNT_ONE  = (logN+1)'(32'sd1);
  localparam logic [logN-1:0] IDX_LAST = logN'(N - 32'sd1);
  localparam logic [logN-1:0] IDX_ONE  = logN'(32'sd1);
  localparam logic [logP:0]   P_EXT    = (logP+1)'(p);
  localparam logic [logP:0]   Q1_W     = (logP+1)'(q_low(p));
  localparam logic [logP:0]   Q3_W     = (logP+1)'(q_high(p));

  state_t state_r, state_next_s;

  logic [logP-1:0] s_r  [N];
  logic [logP-1:0] c0_r [N];
  logic [logP-1:0] c1_r [N];

  logic [logN:0]   kcnt_r, ccnt_r;
  logic [logN-1:0] i_r, j_r;
  logic [logP-1:0] acc_r;
  logic [N-1:0]    shadow_r;
  logic [N-1:0]    message_r;
  logic            msg_valid_r;
  logic            busy_r;

  logic            clr_s, ld_key_s, ld_ciph_s, mul_s, fin_s;
  logic            k_done_s, c_done_s, last_i_s, last_j_s;
  logic [logN-1:0] s_idx_s;
  logic [logP-1:0] prod_s;
  logic [logP:0]   sum_s, sum_red_s, v_sum_s, v_red_s;
  logic [logP-1:0] acc_next_s;
  logic            bit_s;
  logic [N-1:0]    shadow_next_s;

  assign last_i_s = (i_r == IDX_LAST);
  assign last_j_s = (j_r == IDX_LAST);
  assign fin_s    = mul_s && last_i_s && last_j_s;
  // a stream is complete once its counter is full after this cycle's capture
  assign k_done_s = (kcnt_r == CNT_FULL) || (ld_key_s && (kcnt_r == CNT_LAST));
  assign c_done_s = (ccnt_r == CNT_FULL) || (ld_ciph_s && (ccnt_r == CNT_LAST));
  assign s_idx_s  = i_r - j_r;

  mod_mul_p #(.p(p), .logP(logP)) u_mul (
    .a (c1_r[j_r]),
    .b (s_r[s_idx_s]),
    .r (prod_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: if (start) state_next_s = LOAD; else state_next_s = IDLE;
      LOAD: if (k_done_s && c_done_s) state_next_s = MUL; else state_next_s = LOAD;
      MUL:  if (fin_s) state_next_s = DONE; else state_next_s = MUL;
      DONE: state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM control strobes
  always_comb begin
    clr_s     = 1'b0;
    ld_key_s  = 1'b0;
    ld_ciph_s = 1'b0;
    mul_s     = 1'b0;
    case (state_r)
      IDLE: clr_s = start;
      LOAD: begin
        ld_key_s  = key_ready && (kcnt_r != CNT_FULL);
        ld_ciph_s = cipher_ready && (ccnt_r != CNT_FULL);
      end
      MUL:  mul_s = 1'b1;
      DONE: clr_s = 1'b0;
      default: clr_s = 1'b0;
    endcase
  end

  // signed accumulate (negacyclic wrap subtracts), final add of c0 and threshold decode
  always_comb begin
    if (j_r <= i_r) begin
      sum_s = {1'b0, acc_r} + {1'b0, prod_s};
    end else begin
      sum_s = {1'b0, acc_r} + P_EXT - {1'b0, prod_s};
    end
    if (sum_s >= P_EXT) begin
      sum_red_s = sum_s - P_EXT;
    end else begin
      sum_red_s = sum_s;
    end
    acc_next_s = sum_red_s[logP-1:0];
    v_sum_s    = {1'b0, c0_r[i_r]} + {1'b0, acc_next_s};
    if (v_sum_s >= P_EXT) begin
      v_red_s = v_sum_s - P_EXT;
    end else begin
      v_red_s = v_sum_s;
    end
    bit_s              = (v_red_s > Q1_W) && (v_red_s <= Q3_W);
    shadow_next_s      = shadow_r;
    shadow_next_s[i_r] = bit_s;
  end

  // load counters, accumulator and MUL indices
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kcnt_r <= '0;
      ccnt_r <= '0;
      acc_r  <= '0;
      i_r    <= '0;
      j_r    <= '0;
    end else if (clr_s) begin
      kcnt_r <= '0;
      ccnt_r <= '0;
      acc_r  <= '0;
      i_r    <= '0;
      j_r    <= '0;
    end else begin
      if (ld_key_s) kcnt_r <= kcnt_r + CNT_ONE;
      if (ld_ciph_s) ccnt_r <= ccnt_r + CNT_ONE;
      if (mul_s) begin
        j_r <= j_r + IDX_ONE;
        if (last_j_s) begin
          acc_r <= '0;
          i_r   <= i_r + IDX_ONE;
        end else begin
          acc_r <= acc_next_s;
        end
      end
    end
  end

  // coefficient storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        s_r[k]  <= '0;
        c0_r[k] <= '0;
        c1_r[k] <= '0;
      end
    end else begin
      if (ld_key_s) s_r[kcnt_r[logN-1:0]] <= sec_key;
      if (ld_ciph_s) begin
        c0_r[ccnt_r[logN-1:0]] <= cipher_c0;
        c1_r[ccnt_r[logN-1:0]] <= cipher_c1;
      end
    end
  end

  // registered outputs; message lands together with the DONE-cycle valid pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_r    <= '0;
      message_r   <= '0;
      msg_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (mul_s && last_j_s) shadow_r <= shadow_next_s;
      if (fin_s) message_r <= shadow_next_s;
      msg_valid_r <= fin_s;
      busy_r      <= (state_next_s != IDLE);
    end
  end

  assign message   = message_r;
  assign msg_valid = msg_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_dec_rlwe.sv
// Scoreboard bench for dec_rlwe: expected messages come from a full
// polynomial product folded with x^8 = -1, compared when msg_valid pulses.
module tb_dec_rlwe;

  logic       clk;
  logic       reset;
  logic       start;
  logic       key_ready;
  logic [4:0] sec_key;
  logic       cipher_ready;
  logic [4:0] cipher_c0;
  logic [4:0] cipher_c1;
  logic [7:0] message;
  logic       msg_valid;
  logic       busy;

  dec_rlwe dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .key_ready    (key_ready),
    .sec_key      (sec_key),
    .cipher_ready (cipher_ready),
    .cipher_c0    (cipher_c0),
    .cipher_c1    (cipher_c1),
    .message      (message),
    .msg_valid    (msg_valid),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int cyc = 0;
  int last_load_cyc = 0;
  int ks[8];
  int k0[8];
  int k1[8];
  logic [7:0] exp_q[$];
  logic [7:0] last_msg = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model();
    int pr[15];
    int v;
    logic [7:0] m;
    for (int t = 0; t < 15; t++) pr[t] = 0;
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        pr[a+b] += k1[a] * ks[b];
    for (int i = 0; i < 8; i++) begin
      v = k0[i] + pr[i];
      if (i + 8 <= 14) v -= pr[i+8];
      v = v % 17;
      if (v < 0) v += 17;
      m[i] = (v > 4) && (v <= 12);
    end
    return m;
  endfunction

  always @(negedge clk) begin
    if (msg_valid) begin
      vcnt++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_valid", 32'd1, 32'd0);
      end else begin
        check_val("message", {24'd0, message}, {24'd0, exp_q.pop_front()});
        check_val("latency", cyc - last_load_cyc, 65);
      end
    end
  end

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check_val("busy_rise", {31'd0, busy}, 32'd1);
    check_val("msg_hold", {24'd0, message}, {24'd0, last_msg});
  endtask

  // mode 0: streams together; 1: cipher first plus surplus, key gapped; 2: start pulse mid-load
  task automatic do_stream(input int mode);
    if (mode == 1) begin
      for (int k = 0; k < 11; k++) begin
        @(posedge clk); #1;
        cipher_ready = 1'b1;
        cipher_c0 = (k < 8) ? 5'(k0[k]) : 5'd16;
        cipher_c1 = (k < 8) ? 5'(k1[k]) : 5'd16;
      end
      @(posedge clk); #1 cipher_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
        key_ready = 1'b1;
        sec_key = 5'(ks[k]);
        if (k == 7) last_load_cyc = cyc;
        @(posedge clk); #1 key_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
      end
      key_ready = 1'b1; sec_key = 5'd16;
      @(posedge clk); #1 key_ready = 1'b0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        key_ready = 1'b1; sec_key = 5'(ks[k]);
        cipher_ready = 1'b1; cipher_c0 = 5'(k0[k]); cipher_c1 = 5'(k1[k]);
        start = (mode == 2) && (k == 3);
        if (k == 7) last_load_cyc = cyc;
      end
      @(posedge clk); #1;
      key_ready = 1'b0; cipher_ready = 1'b0; start = 1'b0;
    end
  endtask

  task automatic run(input int mode);
    logic [7:0] e;
    int base;
    int n;
    e = model();
    base = vcnt;
    do_start();
    exp_q.push_back(e);
    do_stream(mode);
    if (mode == 2) begin
      repeat (10) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    n = 0;
    while (!msg_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val("done_seen", {31'd0, msg_valid}, 32'd1);
    @(negedge clk);
    check_val("busy_fall", {31'd0, busy}, 32'd0);
    check_val("valid_pulse", {31'd0, msg_valid}, 32'd0);
    repeat (3) @(negedge clk);
    check_val("valid_count", vcnt - base, 1);
    last_msg = e;
  endtask

  task automatic set_vec(input int sel);
    for (int k = 0; k < 8; k++) begin
      ks[k] = 0; k0[k] = 0; k1[k] = 0;
    end
    case (sel)
      0: begin
        for (int k = 0; k < 8; k += 2) k0[k] = 8;
        k1 = '{3, 14, 7, 1, 9, 2, 11, 6};
      end
      1: begin ks[0] = 1; k1 = '{4, 5, 12, 13, 0, 16, 8, 9}; end
      2: begin ks[1] = 1; k1[7] = 8; end
      default: begin
        for (int k = 0; k < 8; k++) begin
          ks[k] = $urandom_range(0, 16);
          k0[k] = $urandom_range(0, 16);
          k1[k] = $urandom_range(0, 16);
        end
      end
    endcase
  endtask

  initial begin
    int base;
    reset = 1'b0; start = 1'b0; key_ready = 1'b0; sec_key = 5'd0;
    cipher_ready = 1'b0; cipher_c0 = 5'd0; cipher_c1 = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_message", {24'd0, message}, 32'd0);
    check_val("rst_valid", {31'd0, msg_valid}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    set_vec(0); run(0);
    set_vec(1); run(0);
    set_vec(2); run(0);
    set_vec(0); run(1);

    set_vec(1);
    base = vcnt;
    do_start();
    do_stream(0);
    repeat (30) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("abort_message", {24'd0, message}, 32'd0);
    check_val("abort_valid", {31'd0, msg_valid}, 32'd0);
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (100) @(negedge clk);
    check_val("abort_no_valid", vcnt - base, 0);
    last_msg = 8'h00;
    run(0);

    set_vec(3); run(2);
    set_vec(3); run(1);
    set_vec(3); run(0);

    check_val("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
